// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage in-order integer
//               pipeline. Detects load-use and branch-operand hazards,
//               selects EX/ID forwarding paths, freezes the back end while
//               data memory is busy and counts stall cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             id_is_branch,
    input  logic             mem_busy,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             bubble_idex,
    output logic             freeze_back,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_br,
    output logic [1:0]       stall_state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HAZ  = 2'b01,
        ST_MEMW = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [1:0]       C_FWD_RF  = 2'b00;
    localparam logic [1:0]       C_FWD_EX  = 2'b01;
    localparam logic [1:0]       C_FWD_MEM = 2'b10;

    // Shadow copies of the destination info of the instructions in EX and MEM
    logic [4:0] r_ex_rd;
    logic       r_ex_wr;
    logic       r_ex_ld;
    logic [4:0] r_mem_rd;
    logic       r_mem_wr;
    logic       r_mem_ld;
    state_t     r_state;

    logic       w_ex_rs1;
    logic       w_ex_rs2;
    logic       w_mem_rs1;
    logic       w_mem_rs2;
    logic       w_load_use;
    logic       w_br_haz;
    logic       w_id_wr;
    logic       w_clear_ex;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    // Write flags exclude r0, so matches against r0 can never occur
    assign w_ex_rs1  = r_ex_wr  & (id_rs1 == r_ex_rd);
    assign w_ex_rs2  = r_ex_wr  & (id_rs2 == r_ex_rd);
    assign w_mem_rs1 = r_mem_wr & (id_rs1 == r_mem_rd);
    assign w_mem_rs2 = r_mem_wr & (id_rs2 == r_mem_rd);

    assign w_load_use = id_valid & r_ex_ld &
                        ((id_use_rs1 & w_ex_rs1) | (id_use_rs2 & w_ex_rs2));
    // A branch resolves in ID: any EX producer, or a load still in MEM, is too late
    assign w_br_haz   = id_valid & id_is_branch & (w_ex_rs1 | (r_mem_ld & w_mem_rs1));

    assign freeze_back = mem_busy;
    assign hold_pc     = mem_busy | w_load_use | w_br_haz;
    assign hold_ifid   = hold_pc;
    assign bubble_idex = (w_load_use | w_br_haz) & ~mem_busy;
    assign fwd_br      = id_is_branch & w_mem_rs1 & ~r_mem_ld;

    assign w_id_wr    = id_regwrite & (id_rd != 5'd0);
    assign w_clear_ex = bubble_idex | ~id_valid;

    // EX/MEM result is newer than MEM/WB, so the EX match has priority
    assign w_fwd_a_nxt = bubble_idex             ? C_FWD_RF  :
                         (id_use_rs1 & w_ex_rs1)  ? C_FWD_EX  :
                         (id_use_rs1 & w_mem_rs1) ? C_FWD_MEM : C_FWD_RF;
    assign w_fwd_b_nxt = bubble_idex             ? C_FWD_RF  :
                         (id_use_rs2 & w_ex_rs2)  ? C_FWD_EX  :
                         (id_use_rs2 & w_mem_rs2) ? C_FWD_MEM : C_FWD_RF;

    // Advance the shadow pipeline and forwarding selects unless the back end is frozen
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex_rd  <= 5'd0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_mem_rd <= 5'd0;
            r_mem_wr <= 1'b0;
            r_mem_ld <= 1'b0;
            fwd_a    <= C_FWD_RF;
            fwd_b    <= C_FWD_RF;
        end else if (!mem_busy) begin
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            r_mem_ld <= r_ex_ld;
            r_ex_rd  <= w_clear_ex ? 5'd0 : id_rd;
            r_ex_wr  <= w_clear_ex ? 1'b0 : w_id_wr;
            r_ex_ld  <= w_clear_ex ? 1'b0 : id_is_load;
            fwd_a    <= w_fwd_a_nxt;
            fwd_b    <= w_fwd_b_nxt;
        end
    end

    // Stall state machine and saturating stall-cycle counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            stall_count <= '0;
        end else begin
            if (mem_busy) begin
                r_state <= ST_MEMW;
            end else if (w_load_use | w_br_haz) begin
                r_state <= ST_HAZ;
            end else begin
                r_state <= ST_RUN;
            end
            if (hold_pc && (stall_count != C_CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign stall_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//==============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl using directed instruction
//               sequences and an expectation queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
    } instr_t;

    typedef struct packed {
        logic       hold;
        logic       bub;
        logic       fbr;
        logic       frz;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] st;
        int         cnt;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0;
    logic [4:0]       id_rs2 = '0;
    logic             id_use_rs1 = 1'b0;
    logic             id_use_rs2 = 1'b0;
    logic [4:0]       id_rd = '0;
    logic             id_regwrite = 1'b0;
    logic             id_is_load = 1'b0;
    logic             id_is_branch = 1'b0;
    logic             mem_busy = 1'b0;
    logic             hold_pc;
    logic             hold_ifid;
    logic             bubble_idex;
    logic             freeze_back;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             fwd_br;
    logic [1:0]       stall_state;
    logic [CNT_W-1:0] stall_count;

    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    exp_t sb[$];

    hazard_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .mem_busy     (mem_busy),
        .hold_pc      (hold_pc),
        .hold_ifid    (hold_ifid),
        .bubble_idex  (bubble_idex),
        .freeze_back  (freeze_back),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .fwd_br       (fwd_br),
        .stall_state  (stall_state),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t i = '0;
        i.valid = 1'b1; i.rd = 5'(rd); i.wr = 1'b1;
        i.rs1 = 5'(rs1); i.use1 = 1'b1; i.rs2 = 5'(rs2); i.use2 = 1'b1;
        return i;
    endfunction

    function automatic instr_t addi(input int rd, input int rs1);
        instr_t i = alu(rd, rs1, 0);
        i.use2 = 1'b0;
        return i;
    endfunction

    function automatic instr_t load(input int rd, input int rs1);
        instr_t i = addi(rd, rs1);
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t beqz(input int rs1);
        instr_t i = '0;
        i.valid = 1'b1; i.rs1 = 5'(rs1); i.use1 = 1'b1; i.br = 1'b1;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic busy);
        id_valid = i.valid; id_rs1 = i.rs1; id_use_rs1 = i.use1;
        id_rs2 = i.rs2; id_use_rs2 = i.use2; id_rd = i.rd;
        id_regwrite = i.wr; id_is_load = i.ld; id_is_branch = i.br;
        mem_busy = busy;
    endtask

    // One pipeline cycle: drive ID, check combinational outputs, clock, check state
    task automatic step(input string tag, input instr_t i, input logic busy,
                        input logic e_hold, input logic e_bub, input logic e_fbr,
                        input logic [1:0] e_fa, input logic [1:0] e_fb,
                        input logic [1:0] e_st);
        exp_t e;
        @(negedge clock);
        drive(i, busy);
        if (e_hold && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
        e = '{hold:e_hold, bub:e_bub, fbr:e_fbr, frz:busy, fa:e_fa, fb:e_fb,
              st:e_st, cnt:exp_cnt};
        sb.push_back(e);
        #2;
        check_eq({tag, ".hold_pc"},     int'(hold_pc),     int'(sb[0].hold));
        check_eq({tag, ".hold_ifid"},   int'(hold_ifid),   int'(sb[0].hold));
        check_eq({tag, ".bubble_idex"}, int'(bubble_idex), int'(sb[0].bub));
        check_eq({tag, ".freeze_back"}, int'(freeze_back), int'(sb[0].frz));
        check_eq({tag, ".fwd_br"},      int'(fwd_br),      int'(sb[0].fbr));
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".fwd_a"},       int'(fwd_a),       int'(e.fa));
        check_eq({tag, ".fwd_b"},       int'(fwd_b),       int'(e.fb));
        check_eq({tag, ".stall_state"}, int'(stall_state), int'(e.st));
        check_eq({tag, ".stall_count"}, int'(stall_count), e.cnt);
    endtask

    task automatic flush();
        step("flush0", nop(), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("flush1", nop(), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        // Reset state
        #3;
        check_eq("rst.fwd_a", int'(fwd_a), 0);
        check_eq("rst.fwd_b", int'(fwd_b), 0);
        check_eq("rst.stall_state", int'(stall_state), 0);
        check_eq("rst.stall_count", int'(stall_count), 0);
        @(negedge clock);
        reset = 1'b1;

        // ALU to ALU: EX forwarding, no stall
        step("add_r3", alu(3, 1, 2), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("sub_r4", alu(4, 3, 1), 1'b0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        flush();

        // Load-use: one bubble, then MEM/WB forwarding on both operands
        step("lw_r5",  load(5, 1),   1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("lu_stl", alu(6, 5, 5), 1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        step("lu_go",  alu(6, 5, 5), 1'b0, 0, 0, 0, 2'b10, 2'b10, 2'b00);
        flush();

        // Load to branch: two stall cycles
        step("lw_r7",  load(7, 1), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("lb_st1", beqz(7),    1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        step("lb_st2", beqz(7),    1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        step("lb_go",  beqz(7),    1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        flush();

        // ALU to branch: one stall cycle, then branch forward from EX/MEM
        step("add_r7", alu(7, 1, 2), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("ab_st1", beqz(7),      1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        step("ab_go",  beqz(7),      1'b0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        flush();

        // Register 0 never forwards nor stalls
        step("addi_r0", addi(0, 1),   1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("add_r0s", alu(2, 0, 0), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("lw_r0",   load(0, 1),   1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("use_r0",  alu(2, 0, 0), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        flush();

        // Memory wait during a load-use stall: freeze holds everything, then one bubble
        step("add_r1", alu(1, 2, 2), 1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("lw_r5b", load(5, 1),   1'b0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("frz%0d", k), alu(6, 5, 5), 1'b1, 1, 0, 0, 2'b01, 2'b00, 2'b10);
        end
        step("frz_bub", alu(6, 5, 5), 1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        step("frz_go",  alu(6, 5, 5), 1'b0, 0, 0, 0, 2'b10, 2'b10, 2'b00);
        flush();

        // Asynchronous reset between edges while in HAZ
        step("lw_r5c", load(5, 1),   1'b0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("pre_rst", alu(6, 5, 5), 1'b0, 1, 1, 0, 2'b00, 2'b00, 2'b01);
        #2;
        reset    = 1'b0;
        mem_busy = 1'b1;
        #1;
        exp_cnt = 0;
        check_eq("arst.fwd_a",       int'(fwd_a),       0);
        check_eq("arst.fwd_b",       int'(fwd_b),       0);
        check_eq("arst.stall_state", int'(stall_state), 0);
        check_eq("arst.stall_count", int'(stall_count), 0);
        check_eq("arst.hold_pc",     int'(hold_pc),     1);
        check_eq("arst.bubble_idex", int'(bubble_idex), 0);
        mem_busy = 1'b0;
        #1;
        check_eq("arst.hold_idle",   int'(hold_pc),     0);
        @(negedge clock);
        drive(nop(), 1'b0);
        reset = 1'b1;

        // Counter saturates at all-ones
        for (int k = 0; k < 18; k++) begin
            step($sformatf("sat%0d", k), nop(), 1'b1, 1, 0, 0, 2'b00, 2'b00, 2'b10);
        end
        check_eq("sat.final", int'(stall_count), 2**CNT_W - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
